mult_result_checker: RTL and testbench
======================================

# mult_result_checker

Self-checking monitor that sits at the output end of the multiplier test environment: it accepts one (A, B, P) triple per handshake, where P is the product reported by the multiplier under test. It recomputes A×B with a sequential shift-add engine and compares the result against P. Pass/fail counts and a per-case result pulse are exported, so benches and on-chip harnesses no longer rely on printed products being checked by hand.

## Interface
Parameters:
- WIDTH, 8, operand width; product width is 2*WIDTH; legal range 2..32
- CNT_W, 16, width of the pass and fail counters

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  triple on in_a/in_b/in_p is valid
- in_ready  out  1  checker can accept a triple
- in_a  in  WIDTH  operand A as driven to the multiplier
- in_b  in  WIDTH  operand B as driven to the multiplier
- in_p  in  2*WIDTH  product returned by the multiplier under test
- clear  in  1  synchronous clear of counters and failure capture
- busy  out  1  a case is in flight (state != IDLE)
- done_valid  out  1  one-cycle pulse, one case finished
- done_pass  out  1  result of that case; valid only with done_valid
- pass_count  out  CNT_W  saturating count of passing cases
- fail_count  out  CNT_W  saturating count of failing cases
- fail_seen  out  1  sticky, at least one failure captured
- fail_a / fail_b  out  WIDTH  operands of the first failing case
- fail_p / fail_exp  out  2*WIDTH  reported and expected product of the first failing case

## Operation
- States: IDLE, MUL, CMP.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready, register a_sh = zero-extended in_a (2*WIDTH bits), b_sh = in_b, p_reg = in_p, acc = 0, step = 0, then go to MUL.
- **MUL**
  - One bit per cycle: if b_sh[0], acc += a_sh (mod 2^(2*WIDTH), never overflows in practice). Then a_sh <<= 1, b_sh >>= 1, step += 1.
  - After WIDTH iterations, go to CMP.
  - No early exit when b_sh becomes 0, so latency is fixed.
- **CMP**
  - Compare acc with p_reg.
  - Register done_valid=1 and done_pass=(acc==p_reg).
  - Increment pass_count or fail_count; both saturate at 2^CNT_W-1.
  - On the first failure while fail_seen=0, capture a, b, p_reg and acc, and set fail_seen.
  - Go to IDLE.
- in_a/in_b/in_p are sampled only at acceptance; later changes have no effect on the case in flight.
- **clear**
  - Zeroes pass_count, fail_count, fail_seen and fail_* on the next edge.
  - When clear coincides with a CMP update, clear wins: counters read 0 afterwards, and that case's done_valid/done_pass pulse still fires.
  - clear does not abort an in-flight case.
- Reset (any time, including mid-case):
  - State returns to IDLE and the in-flight case is dropped, with no done_valid.
  - in_ready=1; busy, done_valid, done_pass, fail_seen = 0.
  - All counters and fail_* = 0.

## Timing
- Acceptance edge k: state becomes MUL after it.
- MUL iterations occur at edges k+1..k+WIDTH.
- CMP evaluates at edge k+WIDTH+1. done_valid and updated counters are visible in the cycle after that edge, i.e. WIDTH+1 cycles after acceptance.
- done_valid is high for exactly one cycle. in_ready is high in that same cycle, so back-to-back acceptance is possible.
- Throughput: one case per WIDTH+2 cycles.
- in_ready is low from acceptance until CMP completes; in_valid may be held without loss.

## Configuration
- MULT_CHECK_FAIL_CAPTURE_EN
  - Defined: first-failure capture registers are built; fail_seen and fail_a/fail_b/fail_p/fail_exp behave as in Operation.
  - Undefined: no capture registers; these outputs are tied to 0.
  - Counters, handshake and done_pass are identical in both builds.

## Test plan
- Reset released, WIDTH=8; accept A=200, B=150, P=30000 -> done_valid 9 cycles after acceptance, done_pass=1, pass_count=1, fail_count=0.
- WIDTH=2; feed A=3, B=3, P=9, then A=1, B=2, P=3 -> first case passes, second fails; fail_count=1, fail_seen=1, fail_a=1, fail_b=2, fail_p=3, fail_exp=2 (capture enabled) or all 0 (disabled).
- Hold in_valid high with back-to-back triples A=255, B=255, P=65025 -> a new acceptance every WIDTH+2=10 cycles; in_ready low during MUL/CMP; no case lost or duplicated.
- CNT_W=2; five passing cases -> pass_count saturates at 3. Assert clear in the same cycle as the sixth CMP -> done_valid pulses, pass_count=0 afterwards.
- Assert rst_n low at step 4 of a case with A=7, B=9 -> no done_valid; all outputs at reset values; next accepted case behaves normally.
- Operand edges A=0, B=255, P=0 and A=255, B=0, P=0 -> both pass, latency still WIDTH+1.

Source files
------------

// File: rtl/mult_result_checker.sv
// mult_result_checker
// Output-side monitor for the multiplier test environment. Each accepted
// (A, B, P) triple is re-multiplied with a one-bit-per-cycle shift-add
// engine and the result is compared with the reported product P. A per-case
// done pulse and saturating pass/fail counters are exported.
//
// Build option: define MULT_CHECK_FAIL_CAPTURE_EN to build the first-failure
// capture registers (fail_seen, fail_a, fail_b, fail_p, fail_exp). Without it
// those outputs are tied to zero.
module mult_result_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [2*WIDTH-1:0]   in_p,
  input  logic                 clear,
  output logic                 busy,
  output logic                 done_valid,
  output logic                 done_pass,
  output logic [CNT_W-1:0]     pass_count,
  output logic [CNT_W-1:0]     fail_count,
  output logic                 fail_seen,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic [2*WIDTH-1:0]   fail_p,
  output logic [2*WIDTH-1:0]   fail_exp
);

  localparam int PW     = 2 * WIDTH;
  localparam int STEP_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;

  logic [1:0]        state;
  logic [STEP_W-1:0] step;
  logic [PW-1:0]     a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [PW-1:0]     p_reg;
  logic [PW-1:0]     acc;
  logic              accept;
  logic              match;
  logic              cmp_now;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign accept   = in_ready && in_valid;
  assign match    = (acc == p_reg);
  assign cmp_now  = (state == S_CMP);

  // Control: sequencing IDLE -> MUL (WIDTH steps, no early exit) -> CMP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      step       <= '0;
      done_valid <= 1'b0;
      done_pass  <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state <= S_MUL;
            step  <= '0;
          end
        end
        S_MUL: begin
          step <= step + STEP_W'(1);
          if (step == STEP_W'(WIDTH - 1)) begin
            state <= S_CMP;
          end
        end
        S_CMP: begin
          done_valid <= 1'b1;
          done_pass  <= match;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath: operands latched on acceptance, then one shift-add per MUL cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh  <= {{WIDTH{1'b0}}, in_a};
      b_sh  <= in_b;
      p_reg <= in_p;
      acc   <= '0;
    end else if (state == S_MUL) begin
      if (b_sh[0]) begin
        acc <= acc + a_sh;
      end
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
    end
  end

  // Pass/fail tallies; clear takes priority over a same-cycle compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_count <= '0;
      fail_count <= '0;
    end else if (clear) begin
      pass_count <= '0;
      fail_count <= '0;
    end else if (cmp_now) begin
      if (match) begin
        pass_count <= sat_inc(pass_count);
      end else begin
        fail_count <= sat_inc(fail_count);
      end
    end
  end

`ifdef MULT_CHECK_FAIL_CAPTURE_EN
  logic [WIDTH-1:0] a_hold;
  logic [WIDTH-1:0] b_hold;

  // Original operands kept unshifted so a failing case can be reported.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_hold <= in_a;
      b_hold <= in_b;
    end
  end

  // First-failure capture, sticky until clear or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_seen <= 1'b0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_p    <= '0;
      fail_exp  <= '0;
    end else if (clear) begin
      fail_seen <= 1'b0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_p    <= '0;
      fail_exp  <= '0;
    end else if (cmp_now && !match && !fail_seen) begin
      fail_seen <= 1'b1;
      fail_a    <= a_hold;
      fail_b    <= b_hold;
      fail_p    <= p_reg;
      fail_exp  <= acc;
    end
  end
`else
  assign fail_seen = 1'b0;
  assign fail_a    = '0;
  assign fail_b    = '0;
  assign fail_p    = '0;
  assign fail_exp  = '0;
`endif

endmodule

// File: tb/tb_mult_result_checker.sv
// Bench for mult_result_checker: a WIDTH=8/CNT_W=16 instance (x_*) and a
// WIDTH=2/CNT_W=2 instance (y_*) share clock and reset. Expected results come
// from plain integer multiplication and a small counter/capture model.
module tb_mult_result_checker;

`ifdef MULT_CHECK_FAIL_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        x_valid = 1'b0, x_ready, x_clear = 1'b0, x_busy, x_dv, x_dp, x_seen;
  logic [7:0]  x_a = '0, x_b = '0, x_fa, x_fb;
  logic [15:0] x_p = '0, x_fp, x_fe, x_pc, x_fc;

  logic        y_valid = 1'b0, y_ready, y_clear = 1'b0, y_busy, y_dv, y_dp, y_seen;
  logic [1:0]  y_a = '0, y_b = '0, y_fa, y_fb, y_pc, y_fc;
  logic [3:0]  y_p = '0, y_fp, y_fe;

  int checks = 0;
  int errors = 0;

  longint unsigned m_pc[2], m_fc[2], m_fa[2], m_fb[2], m_fp[2], m_fe[2];
  bit              m_seen[2];

  mult_result_checker #(.WIDTH(8), .CNT_W(16)) u_x (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x_ready),
    .in_a(x_a), .in_b(x_b), .in_p(x_p), .clear(x_clear), .busy(x_busy),
    .done_valid(x_dv), .done_pass(x_dp), .pass_count(x_pc), .fail_count(x_fc),
    .fail_seen(x_seen), .fail_a(x_fa), .fail_b(x_fb), .fail_p(x_fp), .fail_exp(x_fe)
  );

  mult_result_checker #(.WIDTH(2), .CNT_W(2)) u_y (
    .clk(clk), .rst_n(rst_n), .in_valid(y_valid), .in_ready(y_ready),
    .in_a(y_a), .in_b(y_b), .in_p(y_p), .clear(y_clear), .busy(y_busy),
    .done_valid(y_dv), .done_pass(y_dp), .pass_count(y_pc), .fail_count(y_fc),
    .fail_seen(y_seen), .fail_a(y_fa), .fail_b(y_fb), .fail_p(y_fp), .fail_exp(y_fe)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int wid(input int k);
    return (k == 0) ? 8 : 2;
  endfunction

  function automatic logic rdy(input int k);
    return (k == 0) ? x_ready : y_ready;
  endfunction

  function automatic logic dv(input int k);
    return (k == 0) ? x_dv : y_dv;
  endfunction

  function automatic logic dp(input int k);
    return (k == 0) ? x_dp : y_dp;
  endfunction

  function automatic logic bsy(input int k);
    return (k == 0) ? x_busy : y_busy;
  endfunction

  task automatic drive(input int k, input bit v, input longint unsigned a,
                       input longint unsigned b, input longint unsigned p);
    if (k == 0) begin
      x_valid = v; x_a = a[7:0]; x_b = b[7:0]; x_p = p[15:0];
    end else begin
      y_valid = v; y_a = a[1:0]; y_b = b[1:0]; y_p = p[3:0];
    end
  endtask

  task automatic set_clr(input int k, input bit c);
    if (k == 0) x_clear = c;
    else        y_clear = c;
  endtask

  task automatic model_clear(input int k);
    m_pc[k] = 0; m_fc[k] = 0; m_seen[k] = 1'b0;
    m_fa[k] = 0; m_fb[k] = 0; m_fp[k] = 0; m_fe[k] = 0;
  endtask

  // One finished case: expected product is plain a*b reduced to 2*WIDTH bits.
  task automatic model_done(input int k, input longint unsigned a, input longint unsigned b,
                            input longint unsigned p, input bit clr, output bit pass);
    longint unsigned e, cmax;
    int w;
    w    = wid(k);
    cmax = (k == 0) ? 65535 : 3;
    e    = (a * b) % (64'd1 << (2 * w));
    pass = (e == p);
    if (clr) begin
      model_clear(k);
    end else begin
      if (pass) m_pc[k] = (m_pc[k] < cmax) ? m_pc[k] + 1 : cmax;
      else      m_fc[k] = (m_fc[k] < cmax) ? m_fc[k] + 1 : cmax;
      if (CAP && !pass && !m_seen[k]) begin
        m_seen[k] = 1'b1; m_fa[k] = a; m_fb[k] = b; m_fp[k] = p; m_fe[k] = e;
      end
    end
  endtask

  task automatic check_state(input int k, input string tag);
    if (k == 0) begin
      chk({tag, "_pass_count"}, x_pc, m_pc[0]);
      chk({tag, "_fail_count"}, x_fc, m_fc[0]);
      chk({tag, "_fail_seen"}, x_seen, m_seen[0]);
      chk({tag, "_fail_a"}, x_fa, m_fa[0]);
      chk({tag, "_fail_b"}, x_fb, m_fb[0]);
      chk({tag, "_fail_p"}, x_fp, m_fp[0]);
      chk({tag, "_fail_exp"}, x_fe, m_fe[0]);
    end else begin
      chk({tag, "_pass_count"}, y_pc, m_pc[1]);
      chk({tag, "_fail_count"}, y_fc, m_fc[1]);
      chk({tag, "_fail_seen"}, y_seen, m_seen[1]);
      chk({tag, "_fail_a"}, y_fa, m_fa[1]);
      chk({tag, "_fail_b"}, y_fb, m_fb[1]);
      chk({tag, "_fail_p"}, y_fp, m_fp[1]);
      chk({tag, "_fail_exp"}, y_fe, m_fe[1]);
    end
  endtask

  task automatic check_reset_outputs(input int k, input string tag);
    chk({tag, "_in_ready"}, rdy(k), 1'b1);
    chk({tag, "_busy"}, bsy(k), 1'b0);
    chk({tag, "_done_valid"}, dv(k), 1'b0);
    chk({tag, "_done_pass"}, dp(k), 1'b0);
    check_state(k, tag);
  endtask

  // Called at a negedge; runs one case end to end. clr_lat >= 0 raises clear
  // at that many cycles after acceptance (WIDTH lands it on the CMP edge).
  task automatic run_case(input int k, input longint unsigned a, input longint unsigned b,
                          input longint unsigned p, input int clr_lat, input string tag);
    int  n, lat;
    bit  pass;
    n = 0;
    while (!rdy(k) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_before"}, rdy(k), 1'b1);
    drive(k, 1'b1, a, b, p);
    @(posedge clk);
    @(negedge clk);
    drive(k, 1'b0, $urandom, $urandom, $urandom);
    chk({tag, "_ready_low"}, rdy(k), 1'b0);
    chk({tag, "_busy"}, bsy(k), 1'b1);
    lat = 0;
    while (!dv(k) && lat < 40) begin
      set_clr(k, lat == clr_lat);
      @(negedge clk);
      lat++;
    end
    set_clr(k, 1'b0);
    chk({tag, "_latency"}, lat, wid(k) + 1);
    model_done(k, a, b, p, clr_lat >= 0, pass);
    chk({tag, "_done_pass"}, dp(k), pass);
    chk({tag, "_ready_at_done"}, rdy(k), 1'b1);
    check_state(k, tag);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, dv(k), 1'b0);
  endtask

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned p;
    bit          exp_pass;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int   rd_idx[$];
    int   dones, lat;
    bit   pass;
    longint unsigned ra, rb, rp;

    vecs.push_back('{200, 150, 30000, 1'b1});
    vecs.push_back('{0,   255, 0,     1'b1});
    vecs.push_back('{255, 0,   0,     1'b1});
    vecs.push_back('{255, 255, 65025, 1'b1});
    vecs.push_back('{7,   9,   64,    1'b0});
    vecs.push_back('{128, 2,   256,   1'b1});
    vecs.push_back('{12,  12,  100,   1'b0});
    vecs.push_back('{1,   1,   1,     1'b1});

    model_clear(0);
    model_clear(1);

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs(0, "rst_x");
    check_reset_outputs(1, "rst_y");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table on the 8-bit instance
    foreach (vecs[i]) begin
      chk($sformatf("vec%0d_table_expect", i),
          ((vecs[i].a * vecs[i].b) == vecs[i].p), vecs[i].exp_pass);
      run_case(0, vecs[i].a, vecs[i].b, vecs[i].p, -1, $sformatf("vec%0d", i));
    end

    // Back-to-back with in_valid held: acceptance every WIDTH+2 cycles
    drive(0, 1'b1, 255, 255, 65025);
    dones = 0;
    for (int i = 0; i <= 30; i++) begin
      if (x_ready) rd_idx.push_back(i);
      if (x_dv) begin
        dones++;
        chk("b2b_ready_with_done", x_ready, 1'b1);
      end
      if (i < 30) @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 0, 0, 0);
    lat = 0;
    while (!x_dv && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (x_dv) dones++;
    chk("b2b_last_latency", lat, 9);
    chk("b2b_accepts", rd_idx.size(), 4);
    for (int i = 1; i < rd_idx.size(); i++)
      chk($sformatf("b2b_interval%0d", i), rd_idx[i] - rd_idx[i-1], 10);
    chk("b2b_dones", dones, 4);
    for (int i = 0; i < 4; i++) model_done(0, 255, 255, 65025, 1'b0, pass);
    check_state(0, "b2b");
    @(negedge clk);

    // 2-bit instance: pass then fail with capture
    run_case(1, 3, 3, 9, -1, "w2_pass");
    run_case(1, 1, 2, 3, -1, "w2_fail");

    // Standalone clear while idle
    set_clr(1, 1'b1);
    @(negedge clk);
    set_clr(1, 1'b0);
    model_clear(1);
    check_state(1, "w2_clear");

    // Saturation at 3, then clear on the sixth CMP edge
    for (int i = 0; i < 5; i++) begin
      ra = $urandom_range(3); rb = $urandom_range(3);
      run_case(1, ra, rb, (ra * rb) % 16, -1, $sformatf("sat%0d", i));
    end
    chk("sat_value", y_pc, 2'd3);
    run_case(1, 2, 3, 6, 2, "sat_clear");

    // Clear on the CMP edge of the 8-bit instance, failing case
    run_case(0, 10, 10, 99, 8, "x_clear_cmp");

    // Randomized cases against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom_range(255); rb = $urandom_range(255);
      rp = ra * rb;
      if ($urandom_range(3) == 0) rp = rp ^ (64'd1 << $urandom_range(15));
      run_case(0, ra, rb, rp, -1, $sformatf("rx%0d", i));
    end
    for (int i = 0; i < 15; i++) begin
      ra = $urandom_range(3); rb = $urandom_range(3);
      rp = ra * rb;
      if ($urandom_range(2) == 0) rp = rp ^ (64'd1 << $urandom_range(3));
      run_case(1, ra, rb, rp, -1, $sformatf("ry%0d", i));
    end

    // Reset mid-case at step 4 of A=7, B=9
    drive(0, 1'b1, 7, 9, 63);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 0, 0, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_clear(0);
    model_clear(1);
    check_reset_outputs(0, "midrst_x");
    check_reset_outputs(1, "midrst_y");
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (x_dv) dones++;
    end
    chk("midrst_no_done", dones, 0);
    run_case(0, 7, 9, 63, -1, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
